led_flow_ctrl: RTL and testbench
================================

Name: led_flow_ctrl

Overview:
- Consumes the periodic one-cycle tick from the upstream interval-timer stage and drives an LED bank pattern.
- Each qualifying tick advances the pattern by one step.
- Four selectable patterns, plus run/pause and a per-pattern-cycle completion pulse for downstream status logic.
- Sits between the interval timer and the board LED pins.

Parameters:
- LED_NUM, 4: LED bank width. Legal range 2..16.
- TICK_DIV, 1: ticks per pattern step. Legal range 1..255. 1 means every tick steps.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; synchronous, active-low
- tick  input  1  one-cycle pulse from the interval timer
- en  input  1  1 = run, 0 = pause (pattern and divider frozen)
- mode  input  2  pattern select: 0 rotate-left, 1 rotate-right, 2 ping-pong, 3 blink-all
- led  output  LED_NUM  LED drive, registered
- cycle_done  output  1  one-cycle pulse when the pattern returns to its start state

Behaviour:
- Reset (rst_n=0 sampled on posedge clk):
  - led=1 (LSB only), cycle_done=0, div_cnt=0, dir=left, mode_q=0.
  - Reset asserted mid-pattern overrides everything in that cycle.
- Divider:
  - div_cnt (8 bit) increments on tick&&en.
  - step = tick && en && (div_cnt==TICK_DIV-1); div_cnt wraps to 0 on step.
  - en=0: ticks are ignored and div_cnt holds.
- Latency: led and cycle_done update on the clock edge that samples step, so they are registered one cycle after the tick cycle.
- Mode sampling:
  - mode is sampled only on step.
  - If mode != mode_q at step: mode_q<=mode, dir<=left, led<=init(mode), cycle_done=0, no pattern advance.
  - init = 1 for modes 0/1/2; init = all-ones for mode 3.
  - Mode changes between steps have no effect until the next step.
- Step actions, when mode==mode_q (states keyed on mode_q):
  - ROT_L: led <= {led[LED_NUM-2:0], led[LED_NUM-1]}. cycle_done=1 on the step where the MSB wraps to the LSB (led becomes 1).
  - ROT_R: led <= {led[0], led[LED_NUM-1:1]}. cycle_done=1 when led becomes 1 (the step leaving the LSB→MSB wrap completes at the next arrival at 1).
  - PING:
    - dir=left: shift left; when the new led has the MSB set, dir<=right.
    - dir=right: shift right; when the new led==1, dir<=left and cycle_done=1.
    - Sequence for LED_NUM=4: 0001,0010,0100,1000,0100,0010,0001,...; the MSB and LSB are each shown exactly one step.
  - BLINK: led <= ~led (all-ones ↔ all-zeros). cycle_done=1 on the step to all-ones.
- cycle_done is high for exactly one clk cycle, and 0 in every non-step cycle.
- Simultaneous tick and rst_n=0: reset wins.
- Simultaneous mode change and cycle completion: the re-initialisation wins and cycle_done=0.
- Invariant: in modes 0–2, led is always one-hot.

Optional Feature:
- Macro LED_FLOW_ACTIVE_LOW_EN.
- Defined: the led port drives the bitwise inverse of the internal pattern. Reset value is therefore ~1, i.e. 4'b1110 for LED_NUM=4. All internal state is unchanged.
- Undefined: led is active-high as described above.

Decomposition:
- Package led_flow_pkg holds:
  - the 2-bit mode constants MODE_ROT_L=0, MODE_ROT_R=1, MODE_PING=2, MODE_BLINK=3
  - the direction constants DIR_LEFT/DIR_RIGHT
- One sub-module, tick_div:
  - parameter TICK_DIV; ports clk, rst_n, tick, en → step.
  - Holds div_cnt.
- led_flow_ctrl contains the pattern FSM and output registers.

Test Plan:
- Reset then mode=0, en=1, TICK_DIV=1, LED_NUM=4, 5 ticks → led 0010,0100,1000,0001,0010; cycle_done pulses once, coincident with 0001.
- mode=2, 8 ticks → led 0010,0100,1000,0100,0010,0001,0010,0100; cycle_done only at the 6th step.
- TICK_DIV=3, mode=0, 6 ticks → led changes only after ticks 3 and 6. Pulse en=0 across tick 4 → the change moves to tick 7.
- From led=0100 in mode 0, set mode=3 between ticks → no change until the next tick; then led=1111, cycle_done=0; next tick 0000, next 1111 with cycle_done=1.
- Assert rst_n=0 for 1 cycle coincident with a tick at led=1000 → led=0001, div_cnt=0, cycle_done=0 on the next cycle.
- Build with LED_FLOW_ACTIVE_LOW_EN, LED_NUM=4 → led=1110 after reset; 1101 after the first tick in mode 0.

Source files
------------

// File: rtl/led_flow_pkg.sv
// Shared types for the LED flow controller: pattern-mode and ping-pong direction encodings.
package led_flow_pkg;

    typedef enum logic [1:0] {
        MODE_ROT_L = 2'd0,
        MODE_ROT_R = 2'd1,
        MODE_PING  = 2'd2,
        MODE_BLINK = 2'd3
    } mode_t;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

endpackage

// File: rtl/led_flow_ctrl_tick_div.sv
// Tick prescaler: emits a step on every TICK_DIV-th qualified (tick && en) tick.
module tick_div #(
    parameter int TICK_DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic en,
    output logic step
);

    localparam logic [7:0] CNT_LAST = 8'(TICK_DIV - 1);

    logic [7:0] div_cnt;

    assign step = tick && en && (div_cnt == CNT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt <= 8'd0;
        end else if (tick && en) begin
            div_cnt <= step ? 8'd0 : div_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/led_flow_ctrl.sv
// LED pattern sequencer driven by a divided interval-timer tick.
// Optional build macro LED_FLOW_ACTIVE_LOW_EN inverts the led port for active-low boards.
module led_flow_ctrl
    import led_flow_pkg::*;
#(
    parameter int LED_NUM  = 4,
    parameter int TICK_DIV = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick,
    input  logic               en,
    input  logic [1:0]         mode,
    output logic [LED_NUM-1:0] led,
    output logic               cycle_done
);

    localparam logic [LED_NUM-1:0] PAT_ONE = {{(LED_NUM-1){1'b0}}, 1'b1};
    localparam logic [LED_NUM-1:0] PAT_ALL = {LED_NUM{1'b1}};

    logic               step;
    logic [LED_NUM-1:0] pat_q, pat_d;
    logic [LED_NUM-1:0] led_d;
    dir_t               dir_q, dir_d;
    mode_t              mode_q, mode_d;
    mode_t              mode_in;
    logic               done_d;

    assign mode_in = mode_t'(mode);

    tick_div #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_div (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick),
        .en   (en),
        .step (step)
    );

    // NOTE: every output of this block is defaulted first, so no path leaves a latch behind.
    always_comb begin
        pat_d  = pat_q;
        dir_d  = dir_q;
        mode_d = mode_q;
        done_d = 1'b0;
        if (step) begin
            if (mode_in != mode_q) begin
                // A new mode restarts from its own start state instead of advancing.
                mode_d = mode_in;
                dir_d  = DIR_LEFT;
                pat_d  = (mode_in == MODE_BLINK) ? PAT_ALL : PAT_ONE;
            end else begin
                unique case (mode_q)
                    MODE_ROT_L: begin
                        pat_d  = {pat_q[LED_NUM-2:0], pat_q[LED_NUM-1]};
                        done_d = (pat_d == PAT_ONE);
                    end
                    MODE_ROT_R: begin
                        pat_d  = {pat_q[0], pat_q[LED_NUM-1:1]};
                        done_d = (pat_d == PAT_ONE);
                    end
                    MODE_PING: begin
                        if (dir_q == DIR_LEFT) begin
                            pat_d = pat_q << 1;
                            if (pat_d[LED_NUM-1]) begin
                                dir_d = DIR_RIGHT;
                            end
                        end else begin
                            pat_d = pat_q >> 1;
                            if (pat_d == PAT_ONE) begin
                                dir_d  = DIR_LEFT;
                                done_d = 1'b1;
                            end
                        end
                    end
                    MODE_BLINK: begin
                        pat_d  = ~pat_q;
                        done_d = (pat_d == PAT_ALL);
                    end
                endcase
            end
        end
    end

`ifdef LED_FLOW_ACTIVE_LOW_EN
    assign led_d = ~pat_d;
`else
    assign led_d = pat_d;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pat_q      <= PAT_ONE;
            dir_q      <= DIR_LEFT;
            mode_q     <= MODE_ROT_L;
`ifdef LED_FLOW_ACTIVE_LOW_EN
            led        <= ~PAT_ONE;
`else
            led        <= PAT_ONE;
`endif
            cycle_done <= 1'b0;
        end else begin
            pat_q      <= pat_d;
            dir_q      <= dir_d;
            mode_q     <= mode_d;
            led        <= led_d;
            cycle_done <= done_d;
        end
    end

endmodule

// File: tb/tb_led_flow_ctrl.sv
// Self-checking bench: directed vector table, hand sequences and a randomized run vs a phase-based model.
module tb_led_flow_ctrl;

    localparam int N = 4;

    typedef struct packed {
        logic       rst_n;
        logic       tick;
        logic       en;
        logic [1:0] mode;
    } in_t;

    typedef struct {
        in_t        in;
        logic [3:0] led;
        logic       done;
    } vec_t;

    typedef struct {
        int mode_q;
        int phase;
        int cnt;
        bit done;
    } model_t;

    logic       clk = 1'b0;
    logic       rst1_n, tick1, en1, rst3_n, tick3, en3;
    logic [1:0] mode1, mode3;
    logic [3:0] led1, led3;
    logic       done1, done3;

    int     n_cmp = 0;
    int     n_bad = 0;
    model_t m1, m3;
    vec_t   vecs[$];

    always #5 clk = ~clk;

    led_flow_ctrl #(.LED_NUM(N), .TICK_DIV(1)) dut (
        .clk(clk), .rst_n(rst1_n), .tick(tick1), .en(en1), .mode(mode1),
        .led(led1), .cycle_done(done1)
    );

    led_flow_ctrl #(.LED_NUM(N), .TICK_DIV(3)) dut3 (
        .clk(clk), .rst_n(rst3_n), .tick(tick3), .en(en3), .mode(mode3),
        .led(led3), .cycle_done(done3)
    );

    function automatic in_t mk(logic r, logic t, logic e, logic [1:0] m);
        in_t x;
        x.rst_n = r; x.tick = t; x.en = e; x.mode = m;
        return x;
    endfunction

    function automatic logic [3:0] phys(logic [3:0] p);
`ifdef LED_FLOW_ACTIVE_LOW_EN
        return ~p;
`else
        return p;
`endif
    endfunction

    function automatic int period(int m);
        case (m)
            0, 1:    return N;
            2:       return 2 * N - 2;
            default: return 2;
        endcase
    endfunction

    // The pattern is a pure function of (mode, position within the cycle).
    function automatic logic [3:0] mled(model_t s);
        logic [3:0] v = 4'b0001;
        int idx;
        case (s.mode_q)
            0:       idx = s.phase;
            1:       idx = (N - s.phase) % N;
            2:       idx = (s.phase < N) ? s.phase : (2 * N - 2 - s.phase);
            default: return (s.phase == 0) ? 4'hF : 4'h0;
        endcase
        return v << idx;
    endfunction

    function automatic model_t mstep(model_t s, in_t i, int tdiv);
        model_t n = s;
        n.done = 1'b0;
        if (!i.rst_n) begin
            n.mode_q = 0; n.phase = 0; n.cnt = 0;
        end else if (i.tick && i.en) begin
            n.cnt = s.cnt + 1;
            if (n.cnt == tdiv) begin
                n.cnt = 0;
                if (int'(i.mode) != s.mode_q) begin
                    n.mode_q = int'(i.mode);
                    n.phase  = 0;
                end else begin
                    n.phase = (s.phase + 1) % period(s.mode_q);
                    n.done  = (n.phase == 0);
                end
            end
        end
        return n;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_cycle(input in_t a, input in_t b);
        {rst1_n, tick1, en1, mode1} = a;
        {rst3_n, tick3, en3, mode3} = b;
        @(posedge clk);
        m1 = mstep(m1, a, 1);
        m3 = mstep(m3, b, 3);
        @(negedge clk);
        check("model1_led",  {28'd0, led1}, {28'd0, phys(mled(m1))});
        check("model1_done", {31'd0, done1}, {31'd0, m1.done});
        check("model3_led",  {28'd0, led3}, {28'd0, phys(mled(m3))});
        check("model3_done", {31'd0, done3}, {31'd0, m3.done});
    endtask

    task automatic add(input in_t i, input logic [3:0] l, input logic d);
        vec_t v;
        v.in = i; v.led = l; v.done = d;
        vecs.push_back(v);
    endtask

    task automatic run3(input in_t b, input logic [3:0] l, input string name);
        run_cycle(mk(1, 0, 0, 0), b);
        check(name, {28'd0, led3}, {28'd0, phys(l)});
    endtask

    initial begin
        in_t idle = mk(1, 0, 0, 0);
        in_t rst  = mk(0, 0, 0, 0);
        in_t t0   = mk(1, 1, 1, 0);
        logic [3:0] seq6[6] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0100};
        m1 = '{0, 0, 0, 0};
        m3 = '{0, 0, 0, 0};
        {rst1_n, tick1, en1, mode1} = rst;
        {rst3_n, tick3, en3, mode3} = rst;
        @(negedge clk);

        run_cycle(rst, rst);
        check("reset_led",  {28'd0, led1}, {28'd0, phys(4'b0001)});
        check("reset_done", {31'd0, done1}, 32'd0);

        // Directed table on the TICK_DIV=1 instance.
        add(t0, 4'b0010, 0); add(t0, 4'b0100, 0); add(t0, 4'b1000, 0);
        add(t0, 4'b0001, 1); add(t0, 4'b0010, 0);
        add(mk(1, 0, 1, 0), 4'b0010, 0);
        add(mk(1, 1, 1, 2), 4'b0001, 0);
        add(mk(1, 1, 1, 2), 4'b0010, 0); add(mk(1, 1, 1, 2), 4'b0100, 0);
        add(mk(1, 1, 1, 2), 4'b1000, 0); add(mk(1, 1, 1, 2), 4'b0100, 0);
        add(mk(1, 1, 1, 2), 4'b0010, 0); add(mk(1, 1, 1, 2), 4'b0001, 1);
        add(mk(1, 1, 1, 2), 4'b0010, 0); add(mk(1, 1, 1, 2), 4'b0100, 0);
        add(t0, 4'b0001, 0); add(t0, 4'b0010, 0); add(t0, 4'b0100, 0);
        add(mk(1, 0, 1, 3), 4'b0100, 0);
        add(mk(1, 1, 1, 3), 4'b1111, 0); add(mk(1, 1, 1, 3), 4'b0000, 0);
        add(mk(1, 1, 1, 3), 4'b1111, 1);
        add(t0, 4'b0001, 0); add(t0, 4'b0010, 0); add(t0, 4'b0100, 0);
        add(t0, 4'b1000, 0);
        add(mk(0, 1, 1, 0), 4'b0001, 0);
        add(t0, 4'b0010, 0); add(t0, 4'b0100, 0); add(t0, 4'b1000, 0);
        add(mk(1, 1, 1, 1), 4'b0001, 0);
        add(mk(1, 1, 1, 1), 4'b1000, 0); add(mk(1, 1, 1, 1), 4'b0100, 0);
        add(mk(1, 1, 1, 1), 4'b0010, 0); add(mk(1, 1, 1, 1), 4'b0001, 1);
        add(mk(1, 1, 0, 1), 4'b0001, 0);
        add(mk(1, 1, 1, 1), 4'b1000, 0);
        foreach (vecs[k]) begin
            run_cycle(vecs[k].in, idle);
            check($sformatf("vec%0d_led", k), {28'd0, led1}, {28'd0, phys(vecs[k].led)});
            check($sformatf("vec%0d_done", k), {31'd0, done1}, {31'd0, vecs[k].done});
        end

        // TICK_DIV=3: six ticks, then en=0 across tick 4, then reset mid-count.
        run_cycle(idle, rst);
        for (int i = 0; i < 6; i++) run3(t0, seq6[i], $sformatf("div3_tick%0d", i + 1));
        run_cycle(idle, rst);
        for (int i = 0; i < 3; i++) run3(t0, (i == 2) ? 4'b0010 : 4'b0001, "div3_pre");
        run3(mk(1, 1, 0, 0), 4'b0010, "div3_paused");
        run3(t0, 4'b0010, "div3_t5");
        run3(t0, 4'b0010, "div3_t6");
        run3(t0, 4'b0100, "div3_t7");
        run_cycle(idle, rst);
        run3(t0, 4'b0001, "div3_cnt1");
        run3(t0, 4'b0001, "div3_cnt2");
        run3(mk(0, 1, 1, 0), 4'b0001, "div3_rst_tick");
        run3(t0, 4'b0001, "div3_after_rst1");
        run3(t0, 4'b0001, "div3_after_rst2");
        run3(t0, 4'b0010, "div3_after_rst3");

        // Randomized run against the model for both instances.
        for (int i = 0; i < 3000; i++) begin
            in_t a, b;
            a = mk(($urandom_range(99) != 0), $urandom_range(1), ($urandom_range(4) != 0),
                   ($urandom_range(9) == 0) ? 2'($urandom_range(3)) : 2'(m1.mode_q));
            b = mk(($urandom_range(99) != 0), $urandom_range(1), ($urandom_range(4) != 0),
                   ($urandom_range(9) == 0) ? 2'($urandom_range(3)) : 2'(m3.mode_q));
            run_cycle(a, b);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
